// File: rtl/nand_seq_alu_pkg.sv
// Purpose: shared op codes, FSM state encoding and step-count helper for nand_seq_alu.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nand_seq_pkg;

   localparam logic [2:0] OP_NAND = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_NOT  = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand source and destination selectors for the shared NAND step.
   typedef enum logic [2:0] {
      SRC_A  = 3'd0,
      SRC_B  = 3'd1,
      SRC_T0 = 3'd2,
      SRC_T1 = 3'd3,
      SRC_T2 = 3'd4
   } src_t;

   typedef enum logic [1:0] {
      DST_T0 = 2'd0,
      DST_T1 = 2'd1,
      DST_T2 = 2'd2,
      DST_Y  = 2'd3
   } dst_t;

   // Number of EXEC cycles an op occupies.
   function automatic logic [2:0] steps_for(input logic [2:0] op);
      logic [2:0] n;
      case (op)
         OP_NAND: n = 3'd1;
         OP_AND:  n = 3'd2;
         OP_OR:   n = 3'd3;
         OP_NOR:  n = 3'd4;
         OP_XOR:  n = 3'd4;
         OP_XNOR: n = 3'd5;
         OP_NOT:  n = 3'd1;
         default: n = 3'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/nand_seq_alu_nand_vec.sv
// Purpose: WIDTH-bit bitwise NAND, the only logic datapath of the unit.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y operands; z = ~(x & y).
module nand_vec #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   assign z = ~(x & y);

endmodule

// File: rtl/nand_seq_alu.sv
// Purpose: sequential logic unit building NAND/AND/OR/NOR/XOR/XNOR/NOT from one shared NAND.
// Latency: accept edge N -> out_valid after edge N+steps(op); not pipelined.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
// Ports: clk, rst_n; request in_valid/in_ready with op, a, b;
//        response out_valid/out_ready with y and out_err (illegal op).
module nand_seq_alu
   import nand_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             out_err
);

   state_t           state;
   logic [2:0]       op_q;
   logic [2:0]       step;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] t0, t1, t2;

   src_t             src_x, src_y;
   dst_t             dst;
   logic [WIDTH-1:0] nand_x, nand_y, nand_z;
   logic             last;

   assign in_ready = (state == IDLE);
   assign last     = (step == steps_for(op_q) - 3'd1);

   // Step schedule: which registers feed the NAND this cycle and where the
   // result lands. The final step of every legal op targets y.
   always_comb begin
      src_x = SRC_A;
      src_y = SRC_B;
      dst   = DST_Y;
      case (op_q)
         OP_NOT: src_y = SRC_A;
         OP_AND: begin
            if (step == 3'd0) begin
               dst = DST_T0;
            end else begin
               src_x = SRC_T0;
               src_y = SRC_T0;
            end
         end
         OP_OR, OP_NOR: begin
            case (step)
               3'd0: begin src_x = SRC_A;  src_y = SRC_A;  dst = DST_T0; end
               3'd1: begin src_x = SRC_B;  src_y = SRC_B;  dst = DST_T1; end
               3'd2: begin
                  src_x = SRC_T0;
                  src_y = SRC_T1;
                  dst   = (op_q == OP_NOR) ? DST_T2 : DST_Y;
               end
               default: begin src_x = SRC_T2; src_y = SRC_T2; end
            endcase
         end
         OP_XOR, OP_XNOR: begin
            case (step)
               3'd0: begin src_x = SRC_A;  src_y = SRC_B;  dst = DST_T0; end
               3'd1: begin src_x = SRC_A;  src_y = SRC_T0; dst = DST_T1; end
               3'd2: begin src_x = SRC_B;  src_y = SRC_T0; dst = DST_T2; end
               3'd3: begin
                  src_x = SRC_T1;
                  src_y = SRC_T2;
                  dst   = (op_q == OP_XNOR) ? DST_T0 : DST_Y;
               end
               default: begin src_x = SRC_T0; src_y = SRC_T0; end
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      case (src_x)
         SRC_A:   nand_x = a_q;
         SRC_B:   nand_x = b_q;
         SRC_T0:  nand_x = t0;
         SRC_T1:  nand_x = t1;
         default: nand_x = t2;
      endcase
      case (src_y)
         SRC_A:   nand_y = a_q;
         SRC_B:   nand_y = b_q;
         SRC_T0:  nand_y = t0;
         SRC_T1:  nand_y = t1;
         default: nand_y = t2;
      endcase
   end

   nand_vec #(.WIDTH(WIDTH)) u_nand (
      .x (nand_x),
      .y (nand_y),
      .z (nand_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_NAND;
         step      <= 3'd0;
         a_q       <= '0;
         b_q       <= '0;
         t0        <= '0;
         t1        <= '0;
         t2        <= '0;
         y         <= '0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  a_q   <= a;
                  b_q   <= b;
                  step  <= 3'd0;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (op_q == OP_ILL) begin
                  // Illegal op never touches the datapath.
                  y         <= '0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  case (dst)
                     DST_T0:  t0 <= nand_z;
                     DST_T1:  t1 <= nand_z;
                     DST_T2:  t2 <= nand_z;
                     default: ;
                  endcase
                  step <= step + 3'd1;
                  if (last) begin
                     y         <= nand_z;
                     out_err   <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
